// File: rtl/cnn_div_sdiv_20s_6ns.sv
// Sequential signed/unsigned divider: 20-bit signed dividend by 6-bit unsigned divisor, one restoring step per cycle.
// Define CNN_DIV_REM_EN to produce the signed remainder; otherwise rem is tied to zero.
module cnn_div_sdiv_20s_6ns #(
    parameter logic [31:0] ID             = 32'd1,
    parameter int          DIVIDEND_WIDTH = 20,
    parameter int          DIVISOR_WIDTH  = 6
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      ap_start,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic                      ap_ready,
    output logic                      ap_idle,
    output logic                      ap_done,
    output logic [DIVIDEND_WIDTH-1:0] quot,
    output logic [DIVISOR_WIDTH:0]    rem,
    output logic                      div0
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [4:0] LAST_STEP = 5'd19;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [19:0] work;      // dividend magnitude shifts out the top, quotient bits shift in the bottom
    logic [5:0]  part;
    logic [5:0]  dvs;
    logic        neg;
    logic [19:0] quot_r;
    logic        div0_r;

    logic [19:0] mag;
    logic [6:0]  shifted;
    logic [7:0]  trial;
    logic        qbit;
    logic [5:0]  part_nxt;
    logic [19:0] work_nxt;
    logic        last_step;
    logic        accept;

    assign mag       = din0[19] ? (20'd0 - din0) : din0;
    assign ap_idle   = (state == S_IDLE);
    assign ap_ready  = ap_idle & ap_start;
    assign ap_done   = (state == S_DONE);
    assign accept    = ap_ready;
    assign last_step = (state == S_CALC) && (cnt == LAST_STEP);
    assign quot      = quot_r;
    assign div0      = div0_r;

    // A kept trial subtraction always fits 6 bits because the partial remainder stays below the divisor.
    always_comb begin
        shifted  = {part, work[19]};
        trial    = {1'b0, shifted} - {2'b00, dvs};
        qbit     = ~trial[7];
        part_nxt = qbit ? trial[5:0] : shifted[5:0];
        work_nxt = {work[18:0], qbit};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state  <= S_IDLE;
            cnt    <= 5'd0;
            work   <= 20'd0;
            part   <= 6'd0;
            dvs    <= 6'd0;
            neg    <= 1'b0;
            quot_r <= 20'd0;
            div0_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dvs  <= din1;
                        neg  <= din0[19];
                        work <= mag;
                        part <= 6'd0;
                        cnt  <= 5'd0;
                        if (din1 == 6'd0) begin
                            state  <= S_DONE;
                            quot_r <= 20'd0;
                            div0_r <= 1'b1;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    work <= work_nxt;
                    part <= part_nxt;
                    cnt  <= cnt + 5'd1;
                    if (last_step) begin
                        state  <= S_DONE;
                        cnt    <= 5'd0;
                        quot_r <= neg ? (20'd0 - work_nxt) : work_nxt;
                        div0_r <= 1'b0;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CNN_DIV_REM_EN
    logic [6:0] rem_r;

    // Remainder takes the dividend's sign so that din0 = quot*din1 + rem holds.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rem_r <= 7'd0;
        end else if (accept && (din1 == 6'd0)) begin
            rem_r <= 7'd0;
        end else if (last_step) begin
            rem_r <= neg ? (7'd0 - {1'b0, part_nxt}) : {1'b0, part_nxt};
        end
    end

    assign rem = rem_r;
`else
    assign rem = 7'd0;
`endif

endmodule

// File: tb/tb_cnn_div_sdiv_20s_6ns.sv
// Directed self-checking bench for cnn_div_sdiv_20s_6ns; remainder expectations follow CNN_DIV_REM_EN.
module tb_cnn_div_sdiv_20s_6ns;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic [19:0] din0;
    logic [5:0]  din1;
    logic        ap_ready;
    logic        ap_idle;
    logic        ap_done;
    logic [19:0] quot;
    logic [6:0]  rem;
    logic        div0;

    int errors = 0;
    int checks = 0;

`ifdef CNN_DIV_REM_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    cnn_div_sdiv_20s_6ns dut (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .ap_start(ap_start),
        .din0    (din0),
        .din1    (din1),
        .ap_ready(ap_ready),
        .ap_idle (ap_idle),
        .ap_done (ap_done),
        .quot    (quot),
        .rem     (rem),
        .div0    (div0)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic test_reset();
        ap_rst   = 1'b1;
        ap_start = 1'b0;
        din0     = 20'd0;
        din1     = 6'd0;
        #12;
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", ap_idle); end
        checks++; if (ap_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", ap_done); end
        checks++; if (ap_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ap_ready); end
        checks++; if (quot !== 20'd0) begin errors++; $display("FAIL reset_quot: got %0d expected 0", $signed(quot)); end
        checks++; if (rem !== 7'd0) begin errors++; $display("FAIL reset_rem: got %0d expected 0", $signed(rem)); end
        checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL reset_div0: got %b expected 0", div0); end
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    // One operation: accept, scramble operands after E0, then measure cycles until ap_done.
    task automatic test_divide(input string name, input int a, input int b,
                               input int exp_q, input int exp_r, input int exp_lat);
        int   lat;
        logic rdy;
        logic exp_div0;
        exp_div0 = (b == 0);
        @(negedge ap_clk);
        din0     = 20'(a);
        din1     = 6'(b);
        ap_start = 1'b1;
        #1 rdy = ap_ready;
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_start = 1'b0;
        din0     = 20'h5A5A5;
        din1     = 6'd13;
        lat      = 1;
        while (ap_done !== 1'b1 && lat < 60) begin
            @(negedge ap_clk);
            lat++;
        end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL %s ready: got %b expected 1", name, rdy); end
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat); end
        checks++; if (quot !== 20'(exp_q)) begin errors++; $display("FAIL %s quot: got %0d expected %0d", name, $signed(quot), exp_q); end
        checks++; if (rem !== 7'(REM_EN ? exp_r : 0)) begin errors++; $display("FAIL %s rem: got %0d expected %0d", name, $signed(rem), REM_EN ? exp_r : 0); end
        checks++; if (div0 !== exp_div0) begin errors++; $display("FAIL %s div0: got %b expected %b", name, div0, exp_div0); end
        @(negedge ap_clk);
        checks++; if (ap_done !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b expected 0", name, ap_done); end
    endtask

    task automatic test_back_to_back();
        int a_v[3] = '{-7, 63, 1000};
        int b_v[3] = '{3, 63, 9};
        int q_v[3] = '{-2, 1, 111};
        int r_v[3] = '{-1, 0, 1};
        int acc = 0;
        int nd = 0;
        int cyc = 0;
        int last = 0;
        bit pend = 1'b0;
        bit extra = 1'b0;
        @(negedge ap_clk);
        din0     = 20'(a_v[0]);
        din1     = 6'(b_v[0]);
        ap_start = 1'b1;
        while (nd < 3 && cyc < 200) begin
            #1;
            if (ap_done === 1'b1) begin
                checks++; if (quot !== 20'(q_v[nd])) begin errors++; $display("FAIL b2b%0d quot: got %0d expected %0d", nd, $signed(quot), q_v[nd]); end
                checks++; if (rem !== 7'(REM_EN ? r_v[nd] : 0)) begin errors++; $display("FAIL b2b%0d rem: got %0d expected %0d", nd, $signed(rem), REM_EN ? r_v[nd] : 0); end
                if (nd > 0) begin
                    checks++; if (cyc - last != 22) begin errors++; $display("FAIL b2b%0d spacing: got %0d expected 22", nd, cyc - last); end
                end
                last = cyc;
                nd++;
                if (nd == 3) ap_start = 1'b0;
            end
            if (ap_ready === 1'b1) pend = 1'b1;
            @(negedge ap_clk);
            cyc++;
            if (pend) begin
                pend = 1'b0;
                acc++;
                if (acc < 3) begin
                    din0 = 20'(a_v[acc]);
                    din1 = 6'(b_v[acc]);
                end else begin
                    din0 = 20'hFFFFF;
                    din1 = 6'd0;
                end
            end
        end
        checks++; if (nd != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", nd); end
        repeat (5) begin
            #1 if (ap_idle !== 1'b1 || ap_done !== 1'b0) extra = 1'b1;
            @(negedge ap_clk);
        end
        checks++; if (extra !== 1'b0) begin errors++; $display("FAIL b2b_no_fourth: got %b expected 0", extra); end
    endtask

    task automatic test_reset_abort();
        int lat;
        @(negedge ap_clk);
        din0     = 20'(100);
        din1     = 6'd7;
        ap_start = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (10) @(posedge ap_clk);
        #1 ap_rst = 1'b1;
        #1;
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL abort_idle: got %b expected 1", ap_idle); end
        checks++; if (ap_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", ap_done); end
        checks++; if (quot !== 20'd0) begin errors++; $display("FAIL abort_quot: got %0d expected 0", $signed(quot)); end
        checks++; if (rem !== 7'd0) begin errors++; $display("FAIL abort_rem: got %0d expected 0", $signed(rem)); end
        checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL abort_div0: got %b expected 0", div0); end
        @(negedge ap_clk);
        din0     = 20'(-100);
        din1     = 6'd7;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_start = 1'b0;
        din0     = 20'd0;
        din1     = 6'd1;
        lat      = 1;
        while (ap_done !== 1'b1 && lat < 60) begin
            @(negedge ap_clk);
            lat++;
        end
        checks++; if (lat != 21) begin errors++; $display("FAIL abort_next_latency: got %0d expected 21", lat); end
        checks++; if (quot !== 20'(-14)) begin errors++; $display("FAIL abort_next_quot: got %0d expected -14", $signed(quot)); end
        checks++; if (rem !== 7'(REM_EN ? -2 : 0)) begin errors++; $display("FAIL abort_next_rem: got %0d expected %0d", $signed(rem), REM_EN ? -2 : 0); end
    endtask

    initial begin
        test_reset();
        test_divide("pos_100_7",    100,     7,  14,      2,  21);
        test_divide("neg_100_7",    -100,    7,  -14,     -2, 21);
        test_divide("min_by_1",     -524288, 1,  -524288, 0,  21);
        test_divide("max_by_63",    524287,  63, 8322,    1,  21);
        test_divide("small_pos",    5,       6,  0,       5,  21);
        test_divide("small_neg",    -5,      6,  0,       -5, 21);
        test_divide("div_by_zero",  12345,   0,  0,       0,  1);
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnn_div_sdiv_20s_6ns.md
CNN_DIV_SDIV_20S_6NS -- requirements
Module: cnn_div_sdiv_20s_6ns

Interface
REQ-001 SHALL have parameter ID, default 32'd1, meaning instance identifier (no functional effect).
REQ-002 SHALL have parameter DIVIDEND_WIDTH, default 20, meaning signed dividend width; only 20 is supported.
REQ-003 SHALL have parameter DIVISOR_WIDTH, default 6, meaning unsigned divisor width; only 6 is supported.
REQ-004 SHALL have port ap_clk, input, 1, meaning the single rising-edge clock.
REQ-005 SHALL have port ap_rst, input, 1, meaning the reset, which is asynchronous and active-high.
REQ-006 SHALL have port ap_start, input, 1, meaning request to begin a division.
REQ-007 SHALL have port din0, input, 20, meaning the signed dividend (two's complement).
REQ-008 SHALL have port din1, input, 6, meaning the unsigned divisor.
REQ-009 SHALL have port ap_ready, output, 1, meaning operands are accepted this cycle.
REQ-010 SHALL have port ap_idle, output, 1, meaning the block is in IDLE.
REQ-011 SHALL have port ap_done, output, 1, meaning quot, rem and div0 are valid (one-cycle pulse).
REQ-012 SHALL have port quot, output, 20, meaning the signed quotient.
REQ-013 SHALL have port rem, output, 7, meaning the signed remainder.
REQ-014 SHALL have port div0, output, 1, meaning the divisor was zero.

Function
REQ-015 SHALL implement FSM states IDLE, CALC and DONE.
REQ-016 SHALL drive ap_idle=1 only in IDLE, and drive ap_ready combinationally as ap_idle AND ap_start.
REQ-017 SHALL, on the edge where ap_ready=1 (accept edge E0), register din0 and din1; later operand changes SHALL have no effect.
REQ-018 SHALL, at E0 with din1 nonzero, go to CALC with the iteration count at 0.
REQ-019 SHALL, in CALC, perform one restoring-division step on |din0| per edge, MSB first, for exactly 20 edges (E1..E20), then go to DONE at E20.
REQ-020 SHALL, at E0 with din1=0, go directly to DONE with quot=0, rem=0 and div0=1.
REQ-021 SHALL hold ap_done=1 for exactly the one cycle spent in DONE, then return to IDLE.
- Normal latency: ap_done is high in the cycle after E20.
- Divide-by-zero latency: ap_done is high in the cycle after E0.
REQ-022 SHALL truncate the quotient toward zero.
- Quotient sign = sign(din0).
- Remainder sign = sign(din0).
- |rem| < din1.
- Invariant: din0 = quot*din1 + rem.
- No overflow is possible; quot=-524288 is representable.
REQ-023 SHALL update quot, rem and div0 only on entry to DONE, and hold them until the next DONE entry.
REQ-024 SHALL ignore ap_start while in CALC or DONE; ap_ready=0 there.
REQ-025 SHALL, with ap_start held high continuously, accept a new operation on the first IDLE cycle after DONE (one IDLE cycle between operations).

Reset
REQ-026 SHALL, while ap_rst=1, immediately force state=IDLE, ap_done=0, quot=0, rem=0, div0=0 and the iteration count=0; ap_idle=1.
REQ-027 SHALL abort an in-flight CALC on reset with no ap_done pulse, and SHALL accept again on the first edge after ap_rst deasserts.

Configuration
REQ-028 SHALL use macro CNN_DIV_REM_EN to select remainder support.
- Defined: rem behaves per REQ-022.
- Undefined: rem is tied to 0, and no remainder sign-fixup logic is present.
- quot, div0 and timing SHALL be identical in both builds.

Verification
REQ-029 SHALL cover: din0=100, din1=7 -> quot=14, rem=2, div0=0; ap_done high in the cycle after E20.
REQ-030 SHALL cover: din0=-100, din1=7 -> quot=-14, rem=-2 (rem=0 without CNN_DIV_REM_EN).
REQ-031 SHALL cover: din0=-524288, din1=1 -> quot=-524288, rem=0; din0=524287, din1=63 -> quot=8322, rem=1.
REQ-032 SHALL cover: din0=12345, din1=0 -> div0=1, quot=0, rem=0; ap_done high in the cycle after E0.
REQ-033 SHALL cover: ap_start held high with 3 operand sets -> 3 ap_done pulses spaced 22 cycles apart, each with correct results.
REQ-034 SHALL cover: ap_rst pulsed at E10 of an operation -> no ap_done, outputs=0, ap_idle=1; the next operation completes correctly.
